// File: rtl/spi_sys_reset_sequencer_if.sv
// MMCM supervision bundle between the reset sequencer (slave) and the clocking/system side (master).
// Counter width must match the CNT_W of the sequencer it connects to.
interface spi_sys_reset_sequencer_if #(
    parameter int CNT_W = 8
);
    logic             mmcm_locked_i;
    logic             mmcm_rst_o;
    logic             reset_n_o;
    logic             clock_good_o;
    logic [CNT_W-1:0] timeout_cnt_o;
    logic [CNT_W-1:0] lol_cnt_o;

    modport master (
        output mmcm_locked_i,
        input  mmcm_rst_o,
        input  reset_n_o,
        input  clock_good_o,
        input  timeout_cnt_o,
        input  lol_cnt_o
    );

    modport slave (
        input  mmcm_locked_i,
        output mmcm_rst_o,
        output reset_n_o,
        output clock_good_o,
        output timeout_cnt_o,
        output lol_cnt_o
    );
endinterface

// File: rtl/spi_sys_reset_sequencer.sv
// MMCM lock supervisor on the free-running oscillator: MMCM reset, lock qualification, reset stretch, recovery.
// Define LOCK_STATUS_CNT_EN to build the saturating timeout / loss-of-lock counters; otherwise they read 0.
module spi_sys_reset_sequencer #(
    parameter int MMCM_RST_CYCLES     = 8,
    parameter int LOCK_TIMEOUT_CYCLES = 400000,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int RESET_HOLD_CYCLES   = 16,
    parameter int CNT_W               = 8
) (
    input  logic                      osc_clk_i,
    input  logic                      fpga_rst_n_i,
    spi_sys_reset_sequencer_if.slave  bus
);
    localparam int P_RST  = (MMCM_RST_CYCLES     < 1) ? 1 : MMCM_RST_CYCLES;
    localparam int P_TO   = (LOCK_TIMEOUT_CYCLES < 1) ? 1 : LOCK_TIMEOUT_CYCLES;
    localparam int P_STB  = (LOCK_STABLE_CYCLES  < 1) ? 1 : LOCK_STABLE_CYCLES;
    localparam int P_HOLD = (RESET_HOLD_CYCLES   < 1) ? 1 : RESET_HOLD_CYCLES;
    localparam int P_M1   = (P_RST > P_TO)  ? P_RST : P_TO;
    localparam int P_M2   = (P_STB > P_HOLD) ? P_STB : P_HOLD;
    localparam int P_MAX  = (P_M1 > P_M2)   ? P_M1  : P_M2;
    localparam int TW     = (P_MAX < 2) ? 1 : $clog2(P_MAX);

    localparam logic [TW-1:0] L_RST  = TW'(P_RST  - 1);
    localparam logic [TW-1:0] L_TO   = TW'(P_TO   - 1);
    localparam logic [TW-1:0] L_STB  = TW'(P_STB  - 1);
    localparam logic [TW-1:0] L_HOLD = TW'(P_HOLD - 1);

    typedef enum logic [2:0] {
        S_MMCM_RST,
        S_WAIT_LOCK,
        S_STABLE,
        S_HOLD,
        S_RUN
    } state_t;

    state_t        r_state;
    logic [TW-1:0] r_cnt;
    logic          r_mmcm_rst;
    logic          r_reset_n;
    logic          r_clock_good;
    logic          r_sync1;
    logic          r_sync2;
    logic          w_lock_s;
    logic          w_cnt_zero;

    assign w_lock_s   = r_sync2;
    assign w_cnt_zero = (r_cnt == '0);

    // LOCKED from an MMCM held in reset is stale, so the synchronizer is flushed
    // while pulsing RST; a fresh lock then always pays the full 2-cycle sync delay.
    always_ff @(posedge osc_clk_i or negedge fpga_rst_n_i) begin
        if (!fpga_rst_n_i) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else if (r_state == S_MMCM_RST) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= bus.mmcm_locked_i;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge osc_clk_i or negedge fpga_rst_n_i) begin
        if (!fpga_rst_n_i) begin
            r_state      <= S_MMCM_RST;
            r_cnt        <= L_RST;
            r_mmcm_rst   <= 1'b1;
            r_reset_n    <= 1'b0;
            r_clock_good <= 1'b0;
        end else begin
            case (r_state)
                S_MMCM_RST: begin
                    if (w_cnt_zero) begin
                        r_state    <= S_WAIT_LOCK;
                        r_cnt      <= L_TO;
                        r_mmcm_rst <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_WAIT_LOCK: begin
                    if (w_lock_s) begin
                        r_state <= S_STABLE;
                        r_cnt   <= L_STB;
                    end else if (w_cnt_zero) begin
                        r_state    <= S_MMCM_RST;
                        r_cnt      <= L_RST;
                        r_mmcm_rst <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_STABLE: begin
                    if (!w_lock_s) begin
                        r_state <= S_WAIT_LOCK;
                        r_cnt   <= L_TO;
                    end else if (w_cnt_zero) begin
                        r_state <= S_HOLD;
                        r_cnt   <= L_HOLD;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_HOLD: begin
                    if (!w_lock_s) begin
                        r_state    <= S_MMCM_RST;
                        r_cnt      <= L_RST;
                        r_mmcm_rst <= 1'b1;
                    end else if (w_cnt_zero) begin
                        r_state      <= S_RUN;
                        r_cnt        <= '0;
                        r_reset_n    <= 1'b1;
                        r_clock_good <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_RUN: begin
                    if (!w_lock_s) begin
                        r_state      <= S_MMCM_RST;
                        r_cnt        <= L_RST;
                        r_mmcm_rst   <= 1'b1;
                        r_reset_n    <= 1'b0;
                        r_clock_good <= 1'b0;
                    end
                end
                default: begin
                    r_state      <= S_MMCM_RST;
                    r_cnt        <= L_RST;
                    r_mmcm_rst   <= 1'b1;
                    r_reset_n    <= 1'b0;
                    r_clock_good <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mmcm_rst_o   = r_mmcm_rst;
    assign bus.reset_n_o    = r_reset_n;
    assign bus.clock_good_o = r_clock_good;

`ifdef LOCK_STATUS_CNT_EN
    logic             w_timeout_evt;
    logic             w_lol_evt;
    logic [CNT_W-1:0] r_timeout_cnt;
    logic [CNT_W-1:0] r_lol_cnt;

    // Lock arriving on the timeout cycle wins, so it is not counted as a timeout.
    assign w_timeout_evt = (r_state == S_WAIT_LOCK) && !w_lock_s && w_cnt_zero;
    assign w_lol_evt     = (r_state == S_RUN) && !w_lock_s;

    always_ff @(posedge osc_clk_i or negedge fpga_rst_n_i) begin
        if (!fpga_rst_n_i) begin
            r_timeout_cnt <= '0;
            r_lol_cnt     <= '0;
        end else begin
            if (w_timeout_evt && (r_timeout_cnt != {CNT_W{1'b1}}))
                r_timeout_cnt <= r_timeout_cnt + 1'b1;
            if (w_lol_evt && (r_lol_cnt != {CNT_W{1'b1}}))
                r_lol_cnt <= r_lol_cnt + 1'b1;
        end
    end

    assign bus.timeout_cnt_o = r_timeout_cnt;
    assign bus.lol_cnt_o     = r_lol_cnt;
`else
    assign bus.timeout_cnt_o = {CNT_W{1'b0}};
    assign bus.lol_cnt_o     = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_spi_sys_reset_sequencer.sv
// Directed bench for spi_sys_reset_sequencer: power-up/loss-of-lock vector table plus timeout, glitch,
// async-reset-in-HOLD and counter saturation sequences.
module tb_spi_sys_reset_sequencer;
    localparam int CNT_W = 8;
`ifdef LOCK_STATUS_CNT_EN
    localparam int CE = 1;
`else
    localparam int CE = 0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;

    spi_sys_reset_sequencer_if #(.CNT_W(CNT_W)) bus ();

    spi_sys_reset_sequencer #(
        .MMCM_RST_CYCLES    (3),
        .LOCK_TIMEOUT_CYCLES(100),
        .LOCK_STABLE_CYCLES (8),
        .RESET_HOLD_CYCLES  (4),
        .CNT_W              (CNT_W)
    ) dut (
        .osc_clk_i   (clk),
        .fpga_rst_n_i(rst_n),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int   edge_n;
        logic lk;
        logic mrst;
        logic rn;
        logic cg;
        int   lol;
        int   to;
    } vec_t;

    vec_t tv[15];

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic step_to(input int k);
        while (cyc < k) step();
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s @edge %0d: got %0d, expected %0d", nm, cyc, act, exp);
        end
    endtask

    task automatic do_reset(input logic lk);
        rst_n = 1'b0;
        bus.mmcm_locked_i = lk;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;
    endtask

    task automatic wait_cg(input logic val, input int lim, input string nm, output bit ok);
        int n;
        n = 0;
        while (bus.clock_good_o !== val && n < lim) begin
            step();
            n++;
        end
        ok = (bus.clock_good_o === val);
        if (!ok) begin
            tests++;
            fails++;
            $display("FAIL %s: clock_good_o=%0b, expected %0b within %0d cycles", nm, bus.clock_good_o, val, lim);
        end
    endtask

    initial begin
        int  pulses;
        bit  prev;
        bit  ever_rn;
        bit  ok;

        // edge, locked after this sample, mmcm_rst, reset_n, clock_good, lol, timeouts
        tv[0]  = '{0,  1'b1, 1'b1, 1'b0, 1'b0, 0, 0};
        tv[1]  = '{1,  1'b1, 1'b1, 1'b0, 1'b0, 0, 0};
        tv[2]  = '{2,  1'b1, 1'b1, 1'b0, 1'b0, 0, 0};
        tv[3]  = '{3,  1'b1, 1'b0, 1'b0, 1'b0, 0, 0};
        tv[4]  = '{6,  1'b1, 1'b0, 1'b0, 1'b0, 0, 0};
        tv[5]  = '{17, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0};
        tv[6]  = '{18, 1'b1, 1'b0, 1'b1, 1'b1, 0, 0};
        tv[7]  = '{30, 1'b0, 1'b0, 1'b1, 1'b1, 0, 0};
        tv[8]  = '{32, 1'b0, 1'b0, 1'b1, 1'b1, 0, 0};
        tv[9]  = '{33, 1'b0, 1'b1, 1'b0, 1'b0, 1, 0};
        tv[10] = '{35, 1'b0, 1'b1, 1'b0, 1'b0, 1, 0};
        tv[11] = '{36, 1'b1, 1'b0, 1'b0, 1'b0, 1, 0};
        tv[12] = '{50, 1'b1, 1'b0, 1'b0, 1'b0, 1, 0};
        tv[13] = '{51, 1'b1, 1'b0, 1'b1, 1'b1, 1, 0};
        tv[14] = '{60, 1'b1, 1'b0, 1'b1, 1'b1, 1, 0};

        // Power-up, loss of lock in RUN and recovery
        do_reset(1'b1);
        for (int i = 0; i < 15; i++) begin
            step_to(tv[i].edge_n);
            chk("pu_mmcm_rst",   int'(bus.mmcm_rst_o),    int'(tv[i].mrst));
            chk("pu_reset_n",    int'(bus.reset_n_o),     int'(tv[i].rn));
            chk("pu_clock_good", int'(bus.clock_good_o),  int'(tv[i].cg));
            chk("pu_lol_cnt",    int'(bus.lol_cnt_o),     tv[i].lol * CE);
            chk("pu_timeout_cnt",int'(bus.timeout_cnt_o), tv[i].to * CE);
            $display("[TB] vec %0d edge %0d: rst=%0b rn=%0b cg=%0b lol=%0d to=%0d", i, cyc,
                     bus.mmcm_rst_o, bus.reset_n_o, bus.clock_good_o, bus.lol_cnt_o, bus.timeout_cnt_o);
            bus.mmcm_locked_i = tv[i].lk;
        end

        // Lock timeout: 350 cycles with no lock
        do_reset(1'b0);
        pulses = 0;
        prev = bus.mmcm_rst_o;
        ever_rn = 1'b0;
        for (int i = 0; i < 350; i++) begin
            step();
            if (bus.mmcm_rst_o && !prev) pulses++;
            prev = bus.mmcm_rst_o;
            if (bus.reset_n_o) ever_rn = 1'b1;
            if (cyc == 102) chk("to_cnt_before", int'(bus.timeout_cnt_o), 0);
            if (cyc == 103) chk("to_cnt_first",  int'(bus.timeout_cnt_o), CE);
        end
        chk("to_pulses",   pulses, 3);
        chk("to_cnt",      int'(bus.timeout_cnt_o), 3 * CE);
        chk("to_reset_n",  int'(ever_rn), 0);
        $display("[TB] timeout: pulses=%0d timeout_cnt=%0d", pulses, bus.timeout_cnt_o);

        // Async reset while in HOLD
        bus.mmcm_locked_i = 1'b1;
        step_to(362);
        chk("hold_mmcm_rst", int'(bus.mmcm_rst_o), 0);
        chk("hold_reset_n",  int'(bus.reset_n_o),  0);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_mmcm_rst",    int'(bus.mmcm_rst_o),    1);
        chk("arst_reset_n",     int'(bus.reset_n_o),     0);
        chk("arst_clock_good",  int'(bus.clock_good_o),  0);
        chk("arst_timeout_cnt", int'(bus.timeout_cnt_o), 0);
        $display("[TB] async reset in HOLD: rst=%0b rn=%0b to=%0d", bus.mmcm_rst_o, bus.reset_n_o, bus.timeout_cnt_o);

        // One-cycle lock glitch in STABLE restarts qualification
        do_reset(1'b1);
        step_to(7);
        bus.mmcm_locked_i = 1'b0;
        step();
        bus.mmcm_locked_i = 1'b1;
        step_to(18);
        chk("glitch_rn_e18", int'(bus.reset_n_o), 0);
        step_to(22);
        chk("glitch_rn_e22", int'(bus.reset_n_o), 0);
        step_to(23);
        chk("glitch_rn_e23", int'(bus.reset_n_o),    1);
        chk("glitch_cg_e23", int'(bus.clock_good_o), 1);
        chk("glitch_lol",    int'(bus.lol_cnt_o),    0);
        $display("[TB] glitch: rn=%0b cg=%0b lol=%0d at edge %0d", bus.reset_n_o, bus.clock_good_o, bus.lol_cnt_o, cyc);

        // 300 loss-of-lock events saturate lol_cnt
        do_reset(1'b1);
        for (int i = 0; i < 300; i++) begin
            wait_cg(1'b1, 200, "sat_wait_run", ok);
            if (!ok) break;
            bus.mmcm_locked_i = 1'b0;
            wait_cg(1'b0, 20, "sat_wait_drop", ok);
            if (!ok) break;
            bus.mmcm_locked_i = 1'b1;
        end
        chk("sat_lol_cnt", int'(bus.lol_cnt_o), 255 * CE);
        $display("[TB] saturation: lol_cnt=%0d", bus.lol_cnt_o);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
